// File: rtl/riscv_mem_pkg.sv
// Types shared by the load and store sides of the data-memory path.
// Combinational only; no latency or backpressure of its own.
// Holds the access-size encoding and the buffered store entry layout.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  lanes;
    } store_entry_t;

endpackage

// File: rtl/write_shifter.sv
// Replicates store data onto byte lanes and derives byte enables and misalignment.
// Latency: purely combinational.
// Backpressure: none; evaluated for whatever request is presented.
module write_shifter
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  lanes,
    output logic        misaligned
);

    always_comb begin
        wdata      = data;
        lanes      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            MEM_B: begin
                lanes = 4'b0001 << addr;
                wdata = {4{data[7:0]}};
            end
            MEM_H: begin
                lanes      = 4'b0011 << addr;
                wdata      = {2{data[15:0]}};
                misaligned = addr[0];
            end
            MEM_W: begin
                lanes      = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Queues lane-aligned stores and drains them in order to the data-memory write port.
// Latency: an accepted store reaches mem_* one cycle later when the buffer was empty.
// Backpressure: st_ready drops when full; a slot freed by mem_ack is usable next cycle.
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_misaligned,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_lanes,
    input  logic        mem_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    store_entry_t    entries [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [31:0]     sh_wdata;
    logic [3:0]      sh_lanes;
    logic            sh_mis;
    logic            push;
    logic            pop;
    logic            unused_ld_low;

    write_shifter u_write_shifter (
        .addr       (st_addr[1:0]),
        .size       (st_size),
        .data       (st_data),
        .wdata      (sh_wdata),
        .lanes      (sh_lanes),
        .misaligned (sh_mis)
    );

    assign st_misaligned = st_valid && sh_mis;
    assign st_ready      = (count != FULL_CNT);
    assign empty         = (count == '0);
    assign mem_req       = !empty;
    assign push          = st_valid && st_ready && !sh_mis;
    assign pop           = mem_req && mem_ack;

    assign mem_addr      = {entries[rd_ptr].waddr, 2'b00};
    assign mem_wdata     = entries[rd_ptr].wdata;
    assign mem_lanes     = entries[rd_ptr].lanes;
    assign unused_ld_low = ^ld_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{waddr: st_addr[31:2], wdata: sh_wdata, lanes: sh_lanes};
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Only registered entries are compared, so this cycle's incoming store never hits.
    always_comb begin
        logic [PW-1:0] off;
        off    = '0;
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ((CW'(off) < count) && (entries[i].waddr == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: reference alignment model plus expected-entry queue.
module tb_store_buffer;
    import riscv_mem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = 2'b00;
    logic        st_misaligned;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_lanes;
    logic        mem_ack = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic        empty;

    int checks = 0;
    int failures = 0;
    store_entry_t sb_q[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_size       (st_size),
        .st_misaligned (st_misaligned),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_lanes     (mem_lanes),
        .mem_ack       (mem_ack),
        .ld_addr       (ld_addr),
        .ld_hit        (ld_hit),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_align(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] s, output store_entry_t e,
                                      output logic mis);
        e.waddr = a[31:2];
        e.wdata = d;
        e.lanes = 4'b0000;
        mis     = 1'b0;
        case (s)
            2'b00: begin
                case (a[1:0])
                    2'd0: e.lanes = 4'b0001;
                    2'd1: e.lanes = 4'b0010;
                    2'd2: e.lanes = 4'b0100;
                    default: e.lanes = 4'b1000;
                endcase
                e.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
            end
            2'b01: begin
                e.lanes = a[1] ? 4'b1100 : 4'b0011;
                e.wdata = {d[15:0], d[15:0]};
                mis     = a[0];
            end
            2'b10: begin
                e.lanes = 4'b1111;
                mis     = (a[1:0] != 2'b00);
            end
            default: mis = 1'b1;
        endcase
    endfunction

    // One clock: check outputs at the falling edge, then update the model after the rising edge.
    task automatic step();
        store_entry_t e;
        logic mis;
        logic exp_hit;
        logic do_push;
        logic do_pop;
        @(negedge clk);
        ref_align(st_addr, st_data, st_size, e, mis);
        exp_hit = 1'b0;
        foreach (sb_q[i]) if (sb_q[i].waddr == ld_addr[31:2]) exp_hit = 1'b1;
        chk("st_misaligned", 32'(st_misaligned), 32'(st_valid && mis));
        chk("st_ready", 32'(st_ready), 32'(sb_q.size() < DEPTH));
        chk("empty", 32'(empty), 32'(sb_q.size() == 0));
        chk("mem_req", 32'(mem_req), 32'(sb_q.size() != 0));
        chk("ld_hit", 32'(ld_hit), 32'(exp_hit));
        if (sb_q.size() != 0) begin
            chk("mem_addr", mem_addr, {sb_q[0].waddr, 2'b00});
            chk("mem_wdata", mem_wdata, sb_q[0].wdata);
            chk("mem_lanes", 32'(mem_lanes), 32'(sb_q[0].lanes));
        end
        do_push = st_valid && (sb_q.size() < DEPTH) && !mis;
        do_pop  = mem_ack && (sb_q.size() != 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(sb_q.pop_front());
        if (do_push) sb_q.push_back(e);
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic drain(input int n);
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (n) step();
        mem_ack  = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_st_ready", 32'(st_ready), 32'd1);
        chk("reset_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte store to the top lane.
        set_store(32'h0000_1003, 32'h0000_00A5, 2'b00);
        step();
        st_valid = 1'b0;
        chk("t1_addr", mem_addr, 32'h0000_1000);
        chk("t1_lanes", 32'(mem_lanes), 32'h8);
        chk("t1_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t1_empty_after_ack", 32'(empty), 32'd1);

        // Half store plus misaligned variants.
        set_store(32'h0000_2002, 32'h1234_BEEF, 2'b01);
        step();
        chk("t2_lanes", 32'(mem_lanes), 32'hC);
        chk("t2_wdata", mem_wdata, 32'hBEEF_BEEF);
        set_store(32'h0000_2001, 32'h1111_2222, 2'b01);
        #1 chk("t2_half_mis", 32'(st_misaligned), 32'd1);
        step();
        set_store(32'h0000_2002, 32'hCAFE_F00D, 2'b10);
        #1 chk("t2_word_mis", 32'(st_misaligned), 32'd1);
        step();
        set_store(32'h0000_2000, 32'h0BAD_0BAD, 2'b11);
        #1 chk("t2_size11_mis", 32'(st_misaligned), 32'd1);
        step();
        drain(2);

        // Fill to DEPTH, hold a fifth, free one slot, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            set_store(32'h0000_4000 + 32'(i * 4), 32'hD000_0000 + 32'(i), 2'b10);
            step();
        end
        chk("t3_full_not_ready", 32'(st_ready), 32'd0);
        set_store(32'h0000_4010, 32'hD000_0004, 2'b10);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t3_ready_after_ack", 32'(st_ready), 32'd1);
        step();
        drain(DEPTH + 1);

        // Steady push+ack at count 2, wrapping the pointers.
        for (int i = 0; i < 2; i++) begin
            set_store(32'h0000_5000 + 32'(i * 4), $urandom, 2'b10);
            step();
        end
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_store(32'h0000_5100 + 32'(i * 2), $urandom, 2'(i % 2));
            step();
        end
        drain(3);

        // Load hazard against a buffered word.
        set_store(32'h0000_3000, 32'h5555_AAAA, 2'b10);
        step();
        st_valid = 1'b0;
        ld_addr  = 32'h0000_3002;
        #1 chk("t5_hit_same_word", 32'(ld_hit), 32'd1);
        ld_addr  = 32'h0000_3004;
        #1 chk("t5_hit_next_word", 32'(ld_hit), 32'd0);
        step();
        ld_addr  = 32'h0000_3002;
        mem_ack  = 1'b1;
        step();
        mem_ack  = 1'b0;
        chk("t5_hit_after_ack", 32'(ld_hit), 32'd0);
        step();

        // Asynchronous reset with three entries pending.
        for (int i = 0; i < 3; i++) begin
            set_store(32'h0000_6000 + 32'(i * 4), 32'hE000_0000 + 32'(i), 2'b10);
            step();
        end
        st_valid = 1'b0;
        chk("t6_pre_req", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_mem_addr", mem_addr, 32'd0);
        chk("t6_rst_lanes", 32'(mem_lanes), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_store(32'h0000_7001, 32'h0000_0077, 2'b00);
        step();
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
